// File: rtl/bumpy_game_if.sv
// Signal bundle between the Bumpy game sequencer and its environment
// (key/frame-timing logic in, player FSM / tile loader / HUD out).
interface bumpy_game_if;
  logic       start_keyN;
  logic       frame_tick;
  logic       die;
  logic       level_done;
  logic [2:0] game_state;
  logic       player_resetN;
  logic       level_load;
  logic       freeze;
  logic [2:0] lives;
  logic [2:0] level;
  logic [6:0] time_left;

  modport master (
    input  start_keyN, frame_tick, die, level_done,
    output game_state, player_resetN, level_load, freeze, lives, level, time_left
  );

  modport slave (
    output start_keyN, frame_tick, die, level_done,
    input  game_state, player_resetN, level_load, freeze, lives, level, time_left
  );
endinterface

// File: rtl/bumpy_game_ctrl.sv
// Bumpy game sequencer: lives, level, per-level countdown, freeze and player respawn.
// Optional feature macro: BUMPY_BONUS_LIFE_EN (one extra life per cleared non-final level, max 7).
module bumpy_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int LEVELS         = 4,
  parameter int DIE_FRAMES     = 60,
  parameter int LVL_FRAMES     = 90,
  parameter int FRAMES_PER_SEC = 60,
  parameter int LEVEL_TIME     = 99
) (
  input logic         clk,
  input logic         resetN,
  bumpy_game_if.master game
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PLAY      = 3'd1;
  localparam logic [2:0] S_DYING     = 3'd2;
  localparam logic [2:0] S_RESPAWN   = 3'd3;
  localparam logic [2:0] S_LEVEL_UP  = 3'd4;
  localparam logic [2:0] S_GAME_OVER = 3'd5;
  localparam logic [2:0] S_WIN       = 3'd6;

  localparam int FC_MAX = (DIE_FRAMES > LVL_FRAMES) ? DIE_FRAMES : LVL_FRAMES;
  localparam int FC_W   = $clog2(FC_MAX + 1);
  localparam int SC_W   = $clog2(FRAMES_PER_SEC + 1);

  localparam logic [FC_W-1:0] DIE_LAST   = FC_W'(DIE_FRAMES - 1);
  localparam logic [FC_W-1:0] LVL_LAST   = FC_W'(LVL_FRAMES - 1);
  localparam logic [SC_W-1:0] SEC_LAST   = SC_W'(FRAMES_PER_SEC - 1);
  localparam logic [2:0]      LIVES_INIT = 3'(LIVES);
  localparam logic [2:0]      LEVEL_LAST = 3'(LEVELS - 1);
  localparam logic [6:0]      TIME_INIT  = 7'(LEVEL_TIME);

  logic            key_p0, key_p1, key_p2;
  logic            start_press;
  logic [2:0]      state, state_nx;
  logic [2:0]      lives, lives_nx;
  logic [2:0]      level, level_nx;
  logic [6:0]      time_left, time_nx;
  logic [SC_W-1:0] sec_cnt, sec_nx;
  logic [FC_W-1:0] frame_cnt, fc_nx;
  logic            load_nx;
  logic            player_resetN;
  logic            level_load;

  // Key synchroniser (p0, p1) and edge-detect history (p2); idle level is released (1)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      key_p2 <= 1'b1;
    end else begin
      key_p0 <= game.start_keyN;
      key_p1 <= key_p0;
      key_p2 <= key_p1;
    end
  end

  assign start_press = key_p2 & ~key_p1;

  always_comb begin
    state_nx = state;
    lives_nx = lives;
    level_nx = level;
    time_nx  = time_left;
    sec_nx   = sec_cnt;
    fc_nx    = frame_cnt;
    load_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_press) begin
          lives_nx = LIVES_INIT;
          level_nx = '0;
          load_nx  = 1'b1;
          state_nx = S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        time_nx  = TIME_INIT;
        sec_nx   = '0;
        state_nx = S_PLAY;
      end
      S_PLAY: begin
        if (game.die) begin
          fc_nx    = '0;
          state_nx = S_DYING;
        end else if (game.level_done) begin
          fc_nx    = '0;
          state_nx = S_LEVEL_UP;
        end else if (game.frame_tick) begin
          if (sec_cnt == SEC_LAST) begin
            sec_nx = '0;
            if (time_left == 7'd1) begin
              time_nx  = 7'd0;
              fc_nx    = '0;
              state_nx = S_DYING;
            end else if (time_left != 7'd0) begin
              time_nx = time_left - 7'd1;
            end
          end else begin
            sec_nx = sec_cnt + SC_W'(1);
          end
        end
      end
      S_DYING: begin
        if (game.frame_tick) begin
          if (frame_cnt == DIE_LAST) begin
            if (lives == 3'd1) begin
              lives_nx = 3'd0;
              state_nx = S_GAME_OVER;
            end else begin
              lives_nx = lives - 3'd1;
              state_nx = S_RESPAWN;
            end
          end else begin
            fc_nx = frame_cnt + FC_W'(1);
          end
        end
      end
      S_LEVEL_UP: begin
        if (game.frame_tick) begin
          if (frame_cnt == LVL_LAST) begin
            if (level == LEVEL_LAST) begin
              state_nx = S_WIN;
            end else begin
              level_nx = level + 3'd1;
              load_nx  = 1'b1;
              state_nx = S_RESPAWN;
`ifdef BUMPY_BONUS_LIFE_EN
              lives_nx = (lives == 3'd7) ? lives : lives + 3'd1;
`else
              lives_nx = lives;
`endif
            end
          end else begin
            fc_nx = frame_cnt + FC_W'(1);
          end
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (start_press) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Player is held in reset while idle and for the single respawn clock
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      lives         <= LIVES_INIT;
      level         <= '0;
      time_left     <= TIME_INIT;
      sec_cnt       <= '0;
      frame_cnt     <= '0;
      level_load    <= 1'b0;
      player_resetN <= 1'b0;
    end else begin
      state         <= state_nx;
      lives         <= lives_nx;
      level         <= level_nx;
      time_left     <= time_nx;
      sec_cnt       <= sec_nx;
      frame_cnt     <= fc_nx;
      level_load    <= load_nx;
      player_resetN <= (state_nx != S_IDLE) && (state_nx != S_RESPAWN);
    end
  end

  assign game.game_state    = state;
  assign game.player_resetN = player_resetN;
  assign game.level_load    = level_load;
  assign game.freeze        = (state != S_PLAY);
  assign game.lives         = lives;
  assign game.level         = level;
  assign game.time_left     = time_left;

endmodule

// File: tb/tb_bumpy_game_ctrl.sv
// Directed bench for bumpy_game_ctrl: cycle vector table plus timeout, game-over and
// asynchronous-reset sequences (LIVES=3, LEVELS=2, 4/4 frames, 2 fps, 3 s).
module tb_bumpy_game_ctrl;

`ifdef BUMPY_BONUS_LIFE_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  typedef struct {
    logic       key, tick, die, done;
    logic [2:0] st;
    logic       prst, load, frz;
    logic [2:0] lv, lvl;
    logic [6:0] tl;
  } vec_t;

  logic clk = 1'b0;
  logic resetN;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  bumpy_game_if game();

  bumpy_game_ctrl #(
    .LIVES(3), .LEVELS(2), .DIE_FRAMES(4), .LVL_FRAMES(4),
    .FRAMES_PER_SEC(2), .LEVEL_TIME(3)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .game(game)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic k, input logic t, input logic d, input logic l);
    @(negedge clk);
    game.start_keyN = k;
    game.frame_tick = t;
    game.die        = d;
    game.level_done = l;
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input logic k, t, d, l, input int st, prst, load, frz, lv, lvl, tl);
    vecs.push_back('{k, t, d, l, 3'(st), prst[0], load[0], frz[0], 3'(lv), 3'(lvl), 7'(tl)});
  endtask

  initial begin
    //   key tick die done | state prst load frz lives level time
    add(0,0,0,0, 0,0,0,1, 3,  0,3);
    add(0,0,0,0, 0,0,0,1, 3,  0,3);
    add(0,0,0,0, 3,0,1,1, 3,  0,3);
    add(1,0,0,0, 1,1,0,0, 3,  0,3);
    add(1,1,0,0, 1,1,0,0, 3,  0,3);
    add(1,1,0,0, 1,1,0,0, 3,  0,2);
    add(1,0,0,0, 1,1,0,0, 3,  0,2);
    add(1,1,0,0, 1,1,0,0, 3,  0,2);
    add(1,1,1,0, 2,1,0,1, 3,  0,2);
    add(1,1,1,0, 2,1,0,1, 3,  0,2);
    add(1,1,0,0, 2,1,0,1, 3,  0,2);
    add(1,1,0,0, 2,1,0,1, 3,  0,2);
    add(1,0,0,0, 2,1,0,1, 3,  0,2);
    add(1,1,0,0, 3,0,0,1, 2,  0,2);
    add(1,0,0,0, 1,1,0,0, 2,  0,3);
    add(1,0,0,1, 4,1,0,1, 2,  0,3);
    add(1,1,0,0, 4,1,0,1, 2,  0,3);
    add(1,1,0,0, 4,1,0,1, 2,  0,3);
    add(1,1,0,0, 4,1,0,1, 2,  0,3);
    add(1,1,0,0, 3,0,1,1, 2+B,1,3);
    add(1,0,0,0, 1,1,0,0, 2+B,1,3);
    add(1,0,1,1, 2,1,0,1, 2+B,1,3);
    add(1,1,0,0, 2,1,0,1, 2+B,1,3);
    add(1,1,0,0, 2,1,0,1, 2+B,1,3);
    add(1,1,0,0, 2,1,0,1, 2+B,1,3);
    add(1,1,0,0, 3,0,0,1, 1+B,1,3);
    add(1,0,0,0, 1,1,0,0, 1+B,1,3);
    add(1,0,0,1, 4,1,0,1, 1+B,1,3);
    add(1,1,1,0, 4,1,0,1, 1+B,1,3);
    add(1,1,0,0, 4,1,0,1, 1+B,1,3);
    add(1,1,0,0, 4,1,0,1, 1+B,1,3);
    add(1,1,0,0, 6,1,0,1, 1+B,1,3);
    add(0,0,1,1, 6,1,0,1, 1+B,1,3);
    add(0,0,0,0, 6,1,0,1, 1+B,1,3);
    add(0,0,0,0, 0,0,0,1, 1+B,1,3);
    add(1,0,0,0, 0,0,0,1, 1+B,1,3);

    resetN          = 1'b0;
    game.start_keyN = 1'b1;
    game.frame_tick = 1'b0;
    game.die        = 1'b0;
    game.level_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.state", int'(game.game_state), 0);
    chk("rst.prst", int'(game.player_resetN), 0);
    chk("rst.load", int'(game.level_load), 0);
    chk("rst.freeze", int'(game.freeze), 1);
    chk("rst.lives", int'(game.lives), 3);
    chk("rst.level", int'(game.level), 0);
    chk("rst.time", int'(game.time_left), 3);
    @(negedge clk);
    resetN = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].key, vecs[i].tick, vecs[i].die, vecs[i].done);
      chk($sformatf("v%0d.state", i), int'(game.game_state), int'(vecs[i].st));
      chk($sformatf("v%0d.prst", i), int'(game.player_resetN), int'(vecs[i].prst));
      chk($sformatf("v%0d.load", i), int'(game.level_load), int'(vecs[i].load));
      chk($sformatf("v%0d.freeze", i), int'(game.freeze), int'(vecs[i].frz));
      chk($sformatf("v%0d.lives", i), int'(game.lives), int'(vecs[i].lv));
      chk($sformatf("v%0d.level", i), int'(game.level), int'(vecs[i].lvl));
      chk($sformatf("v%0d.time", i), int'(game.time_left), int'(vecs[i].tl));
    end

    // Timeout death followed by two more deaths to game over
    press();
    chk("a.start.state", int'(game.game_state), 3);
    chk("a.start.load", int'(game.level_load), 1);
    chk("a.start.lives", int'(game.lives), 3);
    chk("a.start.level", int'(game.level), 0);
    step(1, 0, 0, 0);
    chk("a.play.state", int'(game.game_state), 1);
    chk("a.play.prst", int'(game.player_resetN), 1);
    chk("a.play.time", int'(game.time_left), 3);
    for (int k = 1; k <= 6; k++) begin
      step(1, 1, 0, 0);
      chk($sformatf("a.cd%0d.time", k), int'(game.time_left), 3 - k / 2);
      chk($sformatf("a.cd%0d.state", k), int'(game.game_state), (k == 6) ? 2 : 1);
    end
    repeat (4) step(1, 1, 0, 0);
    chk("a.to.state", int'(game.game_state), 3);
    chk("a.to.lives", int'(game.lives), 2);
    chk("a.to.load", int'(game.level_load), 0);
    step(1, 0, 0, 0);
    chk("a.to.time", int'(game.time_left), 3);
    step(1, 0, 1, 0);
    chk("a.d2.state", int'(game.game_state), 2);
    repeat (4) step(1, 1, 1, 0);
    chk("a.d2.lives", int'(game.lives), 1);
    chk("a.d2.rstate", int'(game.game_state), 3);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (4) step(1, 1, 1, 0);
    chk("a.go.state", int'(game.game_state), 5);
    chk("a.go.lives", int'(game.lives), 0);
    chk("a.go.prst", int'(game.player_resetN), 1);
    chk("a.go.freeze", int'(game.freeze), 1);
    step(1, 1, 1, 1);
    chk("a.go.hold", int'(game.game_state), 5);
    press();
    chk("a.idle.state", int'(game.game_state), 0);
    chk("a.idle.prst", int'(game.player_resetN), 0);

    // Asynchronous reset in the middle of a death sequence
    step(1, 0, 0, 0);
    press();
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (4) step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("b.pre.time", int'(game.time_left), 2);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("b.pre.state", int'(game.game_state), 2);
    chk("b.pre.lives", int'(game.lives), 2);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("b.rst.state", int'(game.game_state), 0);
    chk("b.rst.lives", int'(game.lives), 3);
    chk("b.rst.time", int'(game.time_left), 3);
    chk("b.rst.prst", int'(game.player_resetN), 0);
    chk("b.rst.freeze", int'(game.freeze), 1);
    @(negedge clk);
    resetN = 1'b1;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("b.post.state", int'(game.game_state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
